// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset CPU: opcodes, functs, FSM states
// and the datapath mux selects used by the control unit, ALU and datapath.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_REG    = 2'd2,
        PC_JUMP   = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_MEM = 2'd1,
        WD_PC4 = 2'd2
    } wr_reg_src_t;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_BR, CLS_LS, CLS_JUMP, CLS_HALT
    } inst_class_t;

    // Anything not recognised falls into CLS_NOP and simply retires from ID.
    function automatic inst_class_t classify(input logic [5:0] op, input logic [5:0] funct);
        inst_class_t c;
        c = CLS_NOP;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL: c = CLS_ALU;
                    FN_JR:                                         c = CLS_JUMP;
                    default:                                       c = CLS_NOP;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: c = CLS_ALU;
            OP_BEQ, OP_BNE:                     c = CLS_BR;
            OP_LW, OP_SW:                       c = CLS_LS;
            OP_J, OP_JAL:                       c = CLS_JUMP;
            OP_HALT:                            c = CLS_HALT;
            default:                            c = CLS_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bus between the IR field split / datapath and the control unit.
// No valid/ready here: every strobe is a level qualified by the next rising clk edge.
interface mc_control_unit_if #(parameter int CNT_W = 32);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             sign;
    logic             pc_wre;
    logic             ir_wre;
    logic             reg_wre;
    logic [1:0]       reg_dst;
    logic [1:0]       wr_reg_src;
    logic             alu_src_a;
    logic             alu_src_b;
    logic             ext_sel;
    logic [2:0]       alu_op;
    logic             mem_rd;
    logic             mem_wr;
    logic [1:0]       pc_src;
    logic [3:0]       state;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] inst_cnt;

    modport master (
        input  op, funct, zero, sign,
        output pc_wre, ir_wre, reg_wre, reg_dst, wr_reg_src, alu_src_a, alu_src_b,
               ext_sel, alu_op, mem_rd, mem_wr, pc_src, state, halted, cycle_cnt, inst_cnt
    );

    modport slave (
        output op, funct, zero, sign,
        input  pc_wre, ir_wre, reg_wre, reg_dst, wr_reg_src, alu_src_a, alu_src_b,
               ext_sel, alu_op, mem_rd, mem_wr, pc_src, state, halted, cycle_cnt, inst_cnt
    );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational ALU-side decode: operation, operand muxes and immediate extension.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       ext_sel
);

    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    FN_SLL: begin
                        alu_op    = ALU_SLL;
                        alu_src_a = 1'b1;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW: alu_src_b = 1'b1;
            OP_SLTI: begin
                alu_op    = ALU_SLT;
                alu_src_b = 1'b1;
            end
            // Logical immediates take the unsigned 16-bit value.
            OP_ANDI: begin
                alu_op    = ALU_AND;
                alu_src_b = 1'b1;
                ext_sel   = 1'b0;
            end
            OP_ORI: begin
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
                ext_sel   = 1'b0;
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the MIPS-subset CPU, plus cycle and retired-instruction
// counters for the debug display.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              reset,
    mc_control_unit_if.master bus
);

    state_t      state_q, state_d;
    inst_class_t cls;
    alu_op_t     dec_alu_op, alu_op;
    logic        dec_src_a, dec_src_b, dec_ext;
    logic        pc_wre, ir_wre, reg_wre, alu_src_a, alu_src_b, ext_sel, mem_rd, mem_wr;
    reg_dst_t    reg_dst;
    wr_reg_src_t wr_reg_src;
    pc_src_t     pc_src;
    logic [CNT_W-1:0] cycle_q, inst_q;
    logic        unused_sign;

    assign cls         = classify(bus.op, bus.funct);
    assign unused_sign = bus.sign;

    mc_alu_decode u_alu_decode (
        .op        (bus.op),
        .funct     (bus.funct),
        .alu_op    (dec_alu_op),
        .alu_src_a (dec_src_a),
        .alu_src_b (dec_src_b),
        .ext_sel   (dec_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = S_IF;
        pc_wre     = 1'b0;
        ir_wre     = 1'b0;
        reg_wre    = 1'b0;
        reg_dst    = DST_RT;
        wr_reg_src = WD_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        ext_sel    = 1'b0;
        alu_op     = ALU_ADD;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        pc_src     = PC_NEXT;
        case (state_q)
            S_IF: begin
                ir_wre  = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (cls)
                    CLS_ALU:  state_d = S_EXE_AL;
                    CLS_BR:   state_d = S_EXE_BR;
                    CLS_LS:   state_d = S_EXE_LS;
                    CLS_HALT: state_d = S_HALT;
                    CLS_JUMP: begin
                        pc_wre = 1'b1;
                        if (bus.op == OP_JAL) begin
                            pc_src     = PC_JUMP;
                            reg_wre    = 1'b1;
                            reg_dst    = DST_RA;
                            wr_reg_src = WD_PC4;
                        end else if (bus.op == OP_J) begin
                            pc_src = PC_JUMP;
                        end else begin
                            pc_src = PC_REG;
                        end
                    end
                    default: pc_wre = 1'b1;
                endcase
            end
            S_EXE_AL, S_EXE_LS: begin
                alu_op    = dec_alu_op;
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
                ext_sel   = dec_ext;
                state_d   = (state_q == S_EXE_AL) ? S_WB_AL : S_MEM;
            end
            S_EXE_BR: begin
                alu_op = ALU_SUB;
                pc_wre = 1'b1;
                if ((bus.op == OP_BEQ && bus.zero) || (bus.op == OP_BNE && !bus.zero))
                    pc_src = PC_BRANCH;
            end
            S_MEM: begin
                if (bus.op == OP_LW) begin
                    mem_rd  = 1'b1;
                    state_d = S_WB_LD;
                end else begin
                    mem_wr = 1'b1;
                    pc_wre = 1'b1;
                end
            end
            S_WB_AL: begin
                reg_wre = 1'b1;
                reg_dst = (bus.op == OP_RTYPE) ? DST_RD : DST_RT;
                pc_wre  = 1'b1;
            end
            S_WB_LD: begin
                reg_wre    = 1'b1;
                wr_reg_src = WD_MEM;
                pc_wre     = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Every instruction ends with exactly one pc_wre, so it doubles as the retire pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            inst_q  <= '0;
        end else begin
            if (state_q != S_HALT) cycle_q <= cycle_q + CNT_W'(1);
            if (pc_wre)            inst_q  <= inst_q + CNT_W'(1);
        end
    end

    assign bus.pc_wre     = pc_wre;
    assign bus.ir_wre     = ir_wre;
    assign bus.reg_wre    = reg_wre;
    assign bus.reg_dst    = reg_dst;
    assign bus.wr_reg_src = wr_reg_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.ext_sel    = ext_sel;
    assign bus.alu_op     = alu_op;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_wr     = mem_wr;
    assign bus.pc_src     = pc_src;
    assign bus.state      = state_q;
    assign bus.halted     = (state_q == S_HALT);
    assign bus.cycle_cnt  = cycle_q;
    assign bus.inst_cnt   = inst_q;

endmodule
